rsv_station_age_queue: RTL and testbench

//  Parametrised, age-ordered (collapsing) reservation station for one execution unit of the Tomasulo pipeline.

---
 rtl/rsv_pkg.sv | 34 +++
 rtl/rsv_operand_wakeup.sv | 25 ++
 rtl/rsv_station_age_queue.sv | 208 ++++++++++++++++++++
 tb/tb_rsv_station_age_queue.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/rsv_pkg.sv
// Shared defaults, operand record and the oldest-ready priority encoder for the
// age-ordered reservation station.
package rsv_pkg;

    localparam int unsigned TAG_W_DEF  = 6;
    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned MAX_DEPTH  = 64;
    localparam int unsigned MAX_IDX_W  = 6;

    typedef struct packed {
        logic                  rdy;
        logic [TAG_W_DEF-1:0]  tag;
        logic [DATA_W_DEF-1:0] val;
    } rsv_operand_t;

    typedef struct packed {
        logic                 found;
        logic [MAX_IDX_W-1:0] idx;
    } rsv_sel_t;

    // Lowest set bit wins: slot 0 is the oldest entry.
    function automatic rsv_sel_t oldest_ready_idx(input logic [MAX_DEPTH-1:0] rdy_vec);
        rsv_sel_t sel;
        sel = '0;
        for (int unsigned i = 0; i < MAX_DEPTH; i++) begin
            if (rdy_vec[i] && !sel.found) begin
                sel.found = 1'b1;
                sel.idx   = MAX_IDX_W'(i);
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/rsv_operand_wakeup.sv
// Next-state of one source operand: a waiting operand captures the CDB result
// when the broadcast tag matches exactly; ready operands pass through untouched.
module rsv_operand_wakeup #(
    parameter int unsigned TAG_W  = 6,
    parameter int unsigned DATA_W = 32
) (
    input  logic              rdy_i,
    input  logic [TAG_W-1:0]  tag_i,
    input  logic [DATA_W-1:0] val_i,
    input  logic              cdb_valid_i,
    input  logic [TAG_W-1:0]  cdb_tag_i,
    input  logic [DATA_W-1:0] cdb_data_i,
    output logic              rdy_o,
    output logic [TAG_W-1:0]  tag_o,
    output logic [DATA_W-1:0] val_o
);

    logic hit;

    assign hit   = !rdy_i && cdb_valid_i && (tag_i == cdb_tag_i);
    assign rdy_o = rdy_i || hit;
    assign tag_o = tag_i;
    assign val_o = hit ? cdb_data_i : val_i;

endmodule

// File: rtl/rsv_station_age_queue.sv
// Collapsing, age-ordered reservation station: entries live in slots
// [0..count-1] with slot 0 oldest; the oldest ready entry issues.
module rsv_station_age_queue
    import rsv_pkg::*;
#(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned TAG_W     = TAG_W_DEF,
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned PAYLOAD_W = 20
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_flush,
    input  logic                         i_disp_valid,
    output logic                         o_disp_rdy,
    input  logic [PAYLOAD_W-1:0]         i_disp_payload,
    input  logic                         i_disp_rs1_rdy,
    input  logic [TAG_W-1:0]             i_disp_rs1_tag,
    input  logic [DATA_W-1:0]            i_disp_rs1_val,
    input  logic                         i_disp_rs2_rdy,
    input  logic [TAG_W-1:0]             i_disp_rs2_tag,
    input  logic [DATA_W-1:0]            i_disp_rs2_val,
    input  logic                         i_cdb_valid,
    input  logic [TAG_W-1:0]             i_cdb_tag,
    input  logic [DATA_W-1:0]            i_cdb_data,
    output logic                         o_iss_valid,
    input  logic                         i_iss_ready,
    output logic [PAYLOAD_W-1:0]         o_iss_payload,
    output logic [DATA_W-1:0]            o_iss_rs1_val,
    output logic [DATA_W-1:0]            o_iss_rs2_val,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_full,
    output logic                         o_empty
);

    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    logic [DEPTH-1:0]     valid_q,   valid_d;
    logic [PAYLOAD_W-1:0] payload_q [DEPTH];
    logic [PAYLOAD_W-1:0] payload_d [DEPTH];
    logic [DEPTH-1:0]     rs1_rdy_q, rs1_rdy_d, rs2_rdy_q, rs2_rdy_d;
    logic [TAG_W-1:0]     rs1_tag_q [DEPTH];
    logic [TAG_W-1:0]     rs1_tag_d [DEPTH];
    logic [TAG_W-1:0]     rs2_tag_q [DEPTH];
    logic [TAG_W-1:0]     rs2_tag_d [DEPTH];
    logic [DATA_W-1:0]    rs1_val_q [DEPTH];
    logic [DATA_W-1:0]    rs1_val_d [DEPTH];
    logic [DATA_W-1:0]    rs2_val_q [DEPTH];
    logic [DATA_W-1:0]    rs2_val_d [DEPTH];
    logic [CNT_W-1:0]     count_q,   count_d;

    // Post-wakeup view of each stored slot
    logic [DEPTH-1:0]     rs1_rdy_w, rs2_rdy_w;
    logic [TAG_W-1:0]     rs1_tag_w [DEPTH];
    logic [TAG_W-1:0]     rs2_tag_w [DEPTH];
    logic [DATA_W-1:0]    rs1_val_w [DEPTH];
    logic [DATA_W-1:0]    rs2_val_w [DEPTH];

    // Compacted source for each slot (itself, or the slot above when shifting)
    logic [DEPTH-1:0]     src_valid, src_rs1_rdy, src_rs2_rdy, shift;
    logic [PAYLOAD_W-1:0] src_payload [DEPTH];
    logic [TAG_W-1:0]     src_rs1_tag [DEPTH];
    logic [TAG_W-1:0]     src_rs2_tag [DEPTH];
    logic [DATA_W-1:0]    src_rs1_val [DEPTH];
    logic [DATA_W-1:0]    src_rs2_val [DEPTH];

    logic                 d1_rdy, d2_rdy;
    logic [TAG_W-1:0]     d1_tag, d2_tag;
    logic [DATA_W-1:0]    d1_val, d2_val;

    logic [DEPTH-1:0]     ready_vec;
    rsv_sel_t             sel;
    logic                 iss_fire, disp_fire;
    logic [CNT_W-1:0]     wr_idx;

    assign o_count    = count_q;
    assign o_full     = (count_q == CNT_W'(DEPTH));
    assign o_empty    = (count_q == '0);
    assign o_disp_rdy = !o_full;

    assign ready_vec  = valid_q & rs1_rdy_q & rs2_rdy_q;
    assign sel        = oldest_ready_idx(MAX_DEPTH'(ready_vec));
    assign iss_fire   = sel.found && i_iss_ready;
    assign disp_fire  = i_disp_valid && o_disp_rdy;
    assign wr_idx     = count_q - CNT_W'(iss_fire);
    assign o_iss_valid = sel.found;

    always_comb begin
        o_iss_payload = '0;
        o_iss_rs1_val = '0;
        o_iss_rs2_val = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (sel.found && (MAX_IDX_W'(i) == sel.idx)) begin
                o_iss_payload = payload_q[i];
                o_iss_rs1_val = rs1_val_q[i];
                o_iss_rs2_val = rs2_val_q[i];
            end
        end
    end

    rsv_operand_wakeup #(.TAG_W(TAG_W), .DATA_W(DATA_W)) u_disp_rs1 (
        .rdy_i(i_disp_rs1_rdy), .tag_i(i_disp_rs1_tag), .val_i(i_disp_rs1_val),
        .cdb_valid_i(i_cdb_valid), .cdb_tag_i(i_cdb_tag), .cdb_data_i(i_cdb_data),
        .rdy_o(d1_rdy), .tag_o(d1_tag), .val_o(d1_val)
    );

    rsv_operand_wakeup #(.TAG_W(TAG_W), .DATA_W(DATA_W)) u_disp_rs2 (
        .rdy_i(i_disp_rs2_rdy), .tag_i(i_disp_rs2_tag), .val_i(i_disp_rs2_val),
        .cdb_valid_i(i_cdb_valid), .cdb_tag_i(i_cdb_tag), .cdb_data_i(i_cdb_data),
        .rdy_o(d2_rdy), .tag_o(d2_tag), .val_o(d2_val)
    );

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        rsv_operand_wakeup #(.TAG_W(TAG_W), .DATA_W(DATA_W)) u_rs1 (
            .rdy_i(rs1_rdy_q[i]), .tag_i(rs1_tag_q[i]), .val_i(rs1_val_q[i]),
            .cdb_valid_i(i_cdb_valid), .cdb_tag_i(i_cdb_tag), .cdb_data_i(i_cdb_data),
            .rdy_o(rs1_rdy_w[i]), .tag_o(rs1_tag_w[i]), .val_o(rs1_val_w[i])
        );

        rsv_operand_wakeup #(.TAG_W(TAG_W), .DATA_W(DATA_W)) u_rs2 (
            .rdy_i(rs2_rdy_q[i]), .tag_i(rs2_tag_q[i]), .val_i(rs2_val_q[i]),
            .cdb_valid_i(i_cdb_valid), .cdb_tag_i(i_cdb_tag), .cdb_data_i(i_cdb_data),
            .rdy_o(rs2_rdy_w[i]), .tag_o(rs2_tag_w[i]), .val_o(rs2_val_w[i])
        );

        assign shift[i] = iss_fire && (MAX_IDX_W'(i) >= sel.idx);

        if (i < DEPTH-1) begin : g_mid
            assign src_valid[i]   = shift[i] ? valid_q[i+1]   : valid_q[i];
            assign src_payload[i] = shift[i] ? payload_q[i+1] : payload_q[i];
            assign src_rs1_rdy[i] = shift[i] ? rs1_rdy_w[i+1] : rs1_rdy_w[i];
            assign src_rs1_tag[i] = shift[i] ? rs1_tag_w[i+1] : rs1_tag_w[i];
            assign src_rs1_val[i] = shift[i] ? rs1_val_w[i+1] : rs1_val_w[i];
            assign src_rs2_rdy[i] = shift[i] ? rs2_rdy_w[i+1] : rs2_rdy_w[i];
            assign src_rs2_tag[i] = shift[i] ? rs2_tag_w[i+1] : rs2_tag_w[i];
            assign src_rs2_val[i] = shift[i] ? rs2_val_w[i+1] : rs2_val_w[i];
        end else begin : g_top
            assign src_valid[i]   = shift[i] ? 1'b0 : valid_q[i];
            assign src_payload[i] = shift[i] ? '0   : payload_q[i];
            assign src_rs1_rdy[i] = shift[i] ? 1'b0 : rs1_rdy_w[i];
            assign src_rs1_tag[i] = shift[i] ? '0   : rs1_tag_w[i];
            assign src_rs1_val[i] = shift[i] ? '0   : rs1_val_w[i];
            assign src_rs2_rdy[i] = shift[i] ? 1'b0 : rs2_rdy_w[i];
            assign src_rs2_tag[i] = shift[i] ? '0   : rs2_tag_w[i];
            assign src_rs2_val[i] = shift[i] ? '0   : rs2_val_w[i];
        end
    end

    always_comb begin
        valid_d   = src_valid;
        payload_d = src_payload;
        rs1_rdy_d = src_rs1_rdy;
        rs1_tag_d = src_rs1_tag;
        rs1_val_d = src_rs1_val;
        rs2_rdy_d = src_rs2_rdy;
        rs2_tag_d = src_rs2_tag;
        rs2_val_d = src_rs2_val;
        count_d   = count_q + CNT_W'(disp_fire) - CNT_W'(iss_fire);
        // Dispatch lands after compaction, so the write slot already accounts for the issue
        if (disp_fire) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (CNT_W'(i) == wr_idx) begin
                    valid_d[i]   = 1'b1;
                    payload_d[i] = i_disp_payload;
                    rs1_rdy_d[i] = d1_rdy;
                    rs1_tag_d[i] = d1_tag;
                    rs1_val_d[i] = d1_val;
                    rs2_rdy_d[i] = d2_rdy;
                    rs2_tag_d[i] = d2_tag;
                    rs2_val_d[i] = d2_val;
                end
            end
        end
        if (i_flush) begin
            valid_d   = '0;
            rs1_rdy_d = '0;
            rs2_rdy_d = '0;
            count_d   = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q   <= '0;
            rs1_rdy_q <= '0;
            rs2_rdy_q <= '0;
            count_q   <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                payload_q[i] <= '0;
                rs1_tag_q[i] <= '0;
                rs1_val_q[i] <= '0;
                rs2_tag_q[i] <= '0;
                rs2_val_q[i] <= '0;
            end
        end else begin
            valid_q   <= valid_d;
            rs1_rdy_q <= rs1_rdy_d;
            rs2_rdy_q <= rs2_rdy_d;
            count_q   <= count_d;
            payload_q <= payload_d;
            rs1_tag_q <= rs1_tag_d;
            rs1_val_q <= rs1_val_d;
            rs2_tag_q <= rs2_tag_d;
            rs2_val_q <= rs2_val_d;
        end
    end

endmodule

// File: tb/tb_rsv_station_age_queue.sv
// Directed bench for the age-ordered reservation station at default parameters.
module tb_rsv_station_age_queue;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_flush;
    logic        i_disp_valid;
    logic        o_disp_rdy;
    logic [19:0] i_disp_payload;
    logic        i_disp_rs1_rdy;
    logic [5:0]  i_disp_rs1_tag;
    logic [31:0] i_disp_rs1_val;
    logic        i_disp_rs2_rdy;
    logic [5:0]  i_disp_rs2_tag;
    logic [31:0] i_disp_rs2_val;
    logic        i_cdb_valid;
    logic [5:0]  i_cdb_tag;
    logic [31:0] i_cdb_data;
    logic        o_iss_valid;
    logic        i_iss_ready;
    logic [19:0] o_iss_payload;
    logic [31:0] o_iss_rs1_val;
    logic [31:0] o_iss_rs2_val;
    logic [2:0]  o_count;
    logic        o_full;
    logic        o_empty;

    int n_cmp = 0;
    int n_err = 0;

    rsv_station_age_queue #(.DEPTH(4), .TAG_W(6), .DATA_W(32), .PAYLOAD_W(20)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush),
        .i_disp_valid(i_disp_valid), .o_disp_rdy(o_disp_rdy), .i_disp_payload(i_disp_payload),
        .i_disp_rs1_rdy(i_disp_rs1_rdy), .i_disp_rs1_tag(i_disp_rs1_tag), .i_disp_rs1_val(i_disp_rs1_val),
        .i_disp_rs2_rdy(i_disp_rs2_rdy), .i_disp_rs2_tag(i_disp_rs2_tag), .i_disp_rs2_val(i_disp_rs2_val),
        .i_cdb_valid(i_cdb_valid), .i_cdb_tag(i_cdb_tag), .i_cdb_data(i_cdb_data),
        .o_iss_valid(o_iss_valid), .i_iss_ready(i_iss_ready), .o_iss_payload(o_iss_payload),
        .o_iss_rs1_val(o_iss_rs1_val), .o_iss_rs2_val(o_iss_rs2_val),
        .o_count(o_count), .o_full(o_full), .o_empty(o_empty)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic disp(input logic [19:0] p,
                        input logic r1, input logic [5:0] t1, input logic [31:0] v1,
                        input logic r2, input logic [5:0] t2, input logic [31:0] v2);
        i_disp_valid   = 1'b1;
        i_disp_payload = p;
        i_disp_rs1_rdy = r1; i_disp_rs1_tag = t1; i_disp_rs1_val = v1;
        i_disp_rs2_rdy = r2; i_disp_rs2_tag = t2; i_disp_rs2_val = v2;
    endtask

    task automatic cdb(input logic v, input logic [5:0] t, input logic [31:0] d);
        i_cdb_valid = v; i_cdb_tag = t; i_cdb_data = d;
    endtask

    initial begin
        i_rst_n = 1'b0; i_flush = 1'b0; i_iss_ready = 1'b0;
        i_disp_valid = 1'b0; i_disp_payload = '0;
        i_disp_rs1_rdy = 1'b0; i_disp_rs1_tag = '0; i_disp_rs1_val = '0;
        i_disp_rs2_rdy = 1'b0; i_disp_rs2_tag = '0; i_disp_rs2_val = '0;
        cdb(1'b0, 6'd0, 32'd0);

        // Reset state
        step();
        chk("rst_empty", o_empty, 1);
        chk("rst_count", o_count, 0);
        chk("rst_iss_valid", o_iss_valid, 0);
        chk("rst_disp_rdy", o_disp_rdy, 1);
        chk("rst_full", o_full, 0);
        chk("rst_iss_payload", o_iss_payload, 0);
        i_rst_n = 1'b1;
        step();
        chk("post_rst_iss_valid", o_iss_valid, 0);

        // Fill with four ready ops A..D
        disp(20'h0000A, 1'b1, 6'd1, 32'hA1, 1'b1, 6'd2, 32'hA2); step();
        disp(20'h0000B, 1'b1, 6'd1, 32'hB1, 1'b1, 6'd2, 32'hB2); step();
        disp(20'h0000C, 1'b1, 6'd1, 32'hC1, 1'b1, 6'd2, 32'hC2); step();
        disp(20'h0000D, 1'b1, 6'd1, 32'hD1, 1'b1, 6'd2, 32'hD2); step();
        chk("fill_full", o_full, 1);
        chk("fill_disp_rdy", o_disp_rdy, 0);
        chk("fill_count", o_count, 4);
        chk("fill_iss_payload", o_iss_payload, 20'h0000A);
        chk("fill_iss_rs1", o_iss_rs1_val, 32'hA1);
        chk("fill_iss_rs2", o_iss_rs2_val, 32'hA2);
        // Full station must reject a dispatch even while an issue fires
        disp(20'h000FF, 1'b1, 6'd1, 32'hF1, 1'b1, 6'd2, 32'hF2);
        i_iss_ready = 1'b1;
        step();
        i_disp_valid = 1'b0;
        chk("full_reject_count", o_count, 3);
        chk("order_B", o_iss_payload, 20'h0000B);
        step();
        chk("order_C", o_iss_payload, 20'h0000C);
        step();
        chk("order_D", o_iss_payload, 20'h0000D);
        chk("order_D_rs1", o_iss_rs1_val, 32'hD1);
        step();
        chk("drain_empty", o_empty, 1);
        chk("drain_iss_valid", o_iss_valid, 0);

        // Slot0 waits on tag 5, slot1 ready: slot1 bypasses the older op
        i_iss_ready = 1'b0;
        disp(20'h00011, 1'b0, 6'd5, 32'h0, 1'b1, 6'd3, 32'h22); step();
        disp(20'h00012, 1'b1, 6'd5, 32'h31, 1'b1, 6'd3, 32'h32); step();
        i_disp_valid = 1'b0;
        chk("wait_sel_younger", o_iss_payload, 20'h00012);
        i_iss_ready = 1'b1;
        step();
        chk("wait_count", o_count, 1);
        chk("wait_not_ready", o_iss_valid, 0);
        cdb(1'b1, 6'd5, 32'hDEADBEEF);
        #1;
        chk("wake_not_same_cycle", o_iss_valid, 0);
        step();
        cdb(1'b0, 6'd0, 32'd0);
        chk("wake_iss_valid", o_iss_valid, 1);
        chk("wake_rs1", o_iss_rs1_val, 32'hDEADBEEF);
        chk("wake_rs2", o_iss_rs2_val, 32'h22);
        chk("wake_payload", o_iss_payload, 20'h00011);
        step();
        chk("wake_drained", o_empty, 1);

        // Dispatch-path bypass; rs1 already ready with matching tag stays put
        i_iss_ready = 1'b0;
        disp(20'h00021, 1'b1, 6'd9, 32'h5, 1'b0, 6'd9, 32'h0);
        cdb(1'b1, 6'd9, 32'h1234);
        step();
        i_disp_valid = 1'b0;
        cdb(1'b0, 6'd0, 32'd0);
        chk("bypass_iss_valid", o_iss_valid, 1);
        chk("bypass_rs2", o_iss_rs2_val, 32'h1234);
        chk("bypass_rs1_kept", o_iss_rs1_val, 32'h5);
        i_iss_ready = 1'b1;
        step();
        chk("bypass_drained", o_empty, 1);

        // Tag 0 is legal; invalid CDB with tag 0 must not wake it
        i_iss_ready = 1'b0;
        disp(20'h00031, 1'b0, 6'd0, 32'h0, 1'b1, 6'd0, 32'h55);
        step();
        i_disp_valid = 1'b0;
        step();
        chk("tag0_idle", o_iss_valid, 0);
        cdb(1'b1, 6'd0, 32'hABC);
        step();
        cdb(1'b0, 6'd0, 32'd0);
        chk("tag0_woken", o_iss_valid, 1);
        chk("tag0_rs1", o_iss_rs1_val, 32'hABC);
        chk("tag0_rs2_kept", o_iss_rs2_val, 32'h55);
        i_iss_ready = 1'b1;
        step();
        chk("tag0_drained", o_empty, 1);

        // Issue slot1 and dispatch E in the same cycle; order becomes P0, P2, E
        i_iss_ready = 1'b0;
        disp(20'h00040, 1'b0, 6'd7, 32'h0, 1'b1, 6'd1, 32'h40); step();
        disp(20'h00041, 1'b1, 6'd1, 32'h41, 1'b1, 6'd1, 32'h42); step();
        disp(20'h00042, 1'b0, 6'd7, 32'h0, 1'b1, 6'd1, 32'h43); step();
        chk("mix_count3", o_count, 3);
        chk("mix_sel_slot1", o_iss_payload, 20'h00041);
        disp(20'h0004E, 1'b1, 6'd1, 32'hE1, 1'b1, 6'd1, 32'hE2);
        i_iss_ready = 1'b1;
        step();
        i_disp_valid = 1'b0;
        i_iss_ready = 1'b0;
        chk("mix_count_stays", o_count, 3);
        chk("mix_only_E_ready", o_iss_payload, 20'h0004E);
        cdb(1'b1, 6'd7, 32'h77);
        step();
        cdb(1'b0, 6'd0, 32'd0);
        chk("mix_P0_first", o_iss_payload, 20'h00040);
        chk("mix_P0_rs1", o_iss_rs1_val, 32'h77);
        i_iss_ready = 1'b1;
        step();
        chk("mix_P2_second", o_iss_payload, 20'h00042);
        chk("mix_P2_rs1", o_iss_rs1_val, 32'h77);
        chk("mix_count2", o_count, 2);
        step();
        chk("mix_E_last", o_iss_payload, 20'h0004E);
        chk("mix_count1", o_count, 1);
        step();
        chk("mix_drained", o_empty, 1);

        // Flush with concurrent dispatch and issue
        i_iss_ready = 1'b0;
        disp(20'h00051, 1'b1, 6'd1, 32'h1, 1'b1, 6'd1, 32'h2); step();
        disp(20'h00052, 1'b1, 6'd1, 32'h3, 1'b1, 6'd1, 32'h4); step();
        disp(20'h00053, 1'b1, 6'd1, 32'h5, 1'b1, 6'd1, 32'h6); step();
        chk("flush_pre_count", o_count, 3);
        disp(20'h00054, 1'b1, 6'd1, 32'h7, 1'b1, 6'd1, 32'h8);
        i_flush = 1'b1;
        i_iss_ready = 1'b1;
        #1;
        chk("flush_cycle_iss_valid", o_iss_valid, 1);
        step();
        i_flush = 1'b0;
        i_disp_valid = 1'b0;
        i_iss_ready = 1'b0;
        chk("flush_empty", o_empty, 1);
        chk("flush_count", o_count, 0);
        chk("flush_iss_valid", o_iss_valid, 0);
        chk("flush_payload", o_iss_payload, 0);

        // Asynchronous reset mid-operation
        disp(20'h00061, 1'b1, 6'd1, 32'h1, 1'b1, 6'd1, 32'h2); step();
        i_disp_valid = 1'b0;
        chk("async_pre_count", o_count, 1);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("async_count", o_count, 0);
        chk("async_empty", o_empty, 1);
        chk("async_iss_valid", o_iss_valid, 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        step();
        chk("async_release_idle", o_iss_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
